// File: rtl/lab2_proc_inflight_drop_unit.sv
// Imem request/response drop unit: throttles fetch at p_max_inflight outstanding
// requests and discards the responses of requests that were in flight at a squash.
module lab2_proc_inflight_drop_unit #(
  parameter int p_msg_nbits    = 47,
  parameter int p_max_inflight = 2,
  localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   squash,
  input  logic                   req_in_val,
  output logic                   req_in_rdy,
  output logic                   req_out_val,
  input  logic                   req_out_rdy,
  input  logic [p_msg_nbits-1:0] resp_in_msg,
  input  logic                   resp_in_val,
  output logic                   resp_in_rdy,
  output logic [p_msg_nbits-1:0] resp_out_msg,
  output logic                   resp_out_val,
  input  logic                   resp_out_rdy,
  output logic [c_cnt_nbits-1:0] num_inflight,
  output logic [c_cnt_nbits-1:0] num_drop_pending
);

  logic [c_cnt_nbits-1:0] inflight_cnt;
  logic [c_cnt_nbits-1:0] drop_cnt;
  logic [c_cnt_nbits-1:0] inflight_next;
  logic [c_cnt_nbits-1:0] drop_next;
  logic                   not_full;
  logic                   req_fire;
  logic                   drop_now;
  logic                   resp_fire;
  logic                   drop_fire;

  assign not_full    = (inflight_cnt < c_cnt_nbits'(p_max_inflight));
  assign req_out_val = req_in_val & not_full;
  assign req_in_rdy  = req_out_rdy & not_full;
  assign req_fire    = req_in_val & req_in_rdy;

  assign drop_now     = (drop_cnt != '0) | squash;
  assign resp_out_msg = resp_in_msg;
  assign resp_out_val = drop_now ? 1'b0 : resp_in_val;
  assign resp_in_rdy  = drop_now ? 1'b1 : resp_out_rdy;
  assign resp_fire    = resp_in_val & resp_in_rdy;
  assign drop_fire    = resp_fire & drop_now;

  assign num_inflight     = inflight_cnt;
  assign num_drop_pending = drop_cnt;

  // Both counters saturate at zero so a stray response cannot wrap them.
  always_comb begin
    inflight_next = inflight_cnt;
    if (req_fire && !resp_fire)
      inflight_next = inflight_cnt + c_cnt_nbits'(1);
    else if (!req_fire && resp_fire && inflight_cnt != '0)
      inflight_next = inflight_cnt - c_cnt_nbits'(1);
  end

  // A squash dooms everything issued in earlier cycles; a request firing in the
  // squash cycle is the redirect target and is not counted.
  always_comb begin
    drop_next = drop_cnt;
    if (squash) begin
      if (resp_fire && inflight_cnt != '0)
        drop_next = inflight_cnt - c_cnt_nbits'(1);
      else
        drop_next = inflight_cnt;
    end else if (drop_fire && drop_cnt != '0) begin
      drop_next = drop_cnt - c_cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      inflight_cnt <= inflight_next;
      drop_cnt     <= drop_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && resp_in_val && inflight_cnt == '0)
      $error("lab2_proc_inflight_drop_unit: response with no request in flight");
  end

  function automatic string line_trace();
    return $sformatf("%0d/%0d%s", inflight_cnt, drop_cnt, drop_fire ? "x" : " ");
  endfunction
`endif

endmodule

// File: tb/tb_lab2_proc_inflight_drop_unit.sv
// Bench for the inflight drop unit: directed vector table, reset sequence, and
// random traffic against a queue-of-outstanding-requests reference model.
module tb_lab2_proc_inflight_drop_unit;

  localparam int MSGW = 47;
  localparam int MAXF = 2;
  localparam int CNTW = $clog2(MAXF + 1);

  logic            clk;
  logic            reset;
  logic            squash;
  logic            req_in_val;
  logic            req_in_rdy;
  logic            req_out_val;
  logic            req_out_rdy;
  logic [MSGW-1:0] resp_in_msg;
  logic            resp_in_val;
  logic            resp_in_rdy;
  logic [MSGW-1:0] resp_out_msg;
  logic            resp_out_val;
  logic            resp_out_rdy;
  logic [CNTW-1:0] num_inflight;
  logic [CNTW-1:0] num_drop_pending;

  int checks   = 0;
  int failures = 0;

  lab2_proc_inflight_drop_unit #(
    .p_msg_nbits(MSGW),
    .p_max_inflight(MAXF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .squash(squash),
    .req_in_val(req_in_val),
    .req_in_rdy(req_in_rdy),
    .req_out_val(req_out_val),
    .req_out_rdy(req_out_rdy),
    .resp_in_msg(resp_in_msg),
    .resp_in_val(resp_in_val),
    .resp_in_rdy(resp_in_rdy),
    .resp_out_msg(resp_out_msg),
    .resp_out_val(resp_out_val),
    .resp_out_rdy(resp_out_rdy),
    .num_inflight(num_inflight),
    .num_drop_pending(num_drop_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            sq, rqv, ordy, rsv, rordy;
    logic [MSGW-1:0] msg;
    logic            e_rqrdy, e_oval, e_rsrdy, e_rsoval;
    int              e_inf, e_drp;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic sq, input logic rqv, input logic ordy,
                       input logic rsv, input logic rordy, input logic [MSGW-1:0] m);
    @(negedge clk);
    squash       = sq;
    req_in_val   = rqv;
    req_out_rdy  = ordy;
    resp_in_val  = rsv;
    resp_out_rdy = rordy;
    resp_in_msg  = m;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic a, input logic b,
                          input logic c, input logic d);
    chk({tag, ".req_in_rdy"},   64'(req_in_rdy),   64'(a));
    chk({tag, ".req_out_val"},  64'(req_out_val),  64'(b));
    chk({tag, ".resp_in_rdy"},  64'(resp_in_rdy),  64'(c));
    chk({tag, ".resp_out_val"}, 64'(resp_out_val), 64'(d));
    chk({tag, ".resp_out_msg"}, 64'(resp_out_msg), 64'(resp_in_msg));
  endtask

  task automatic clock_and_chk_cnt(input string tag, input int inf, input int drp);
    @(posedge clk);
    #1;
    chk({tag, ".num_inflight"},     64'(num_inflight),     64'(inf));
    chk({tag, ".num_drop_pending"}, 64'(num_drop_pending), 64'(drp));
  endtask

  // Reference model: one entry per outstanding request, set when doomed by a squash.
  bit q[$];

  initial begin
    logic            sq, rqv, ordy, rsv, rordy;
    logic [MSGW-1:0] m;
    int              ndoom;
    bit              full, dropping, e_rqrdy, e_oval, e_rsrdy, e_rsoval;

    tbl[0]  = '{0,1,1,0,1, 47'h0,          1,1,1,0, 1,0};
    tbl[1]  = '{0,1,1,0,1, 47'h0,          1,1,1,0, 2,0};
    tbl[2]  = '{0,1,1,1,1, 47'h00000013,   0,0,1,1, 1,0};
    tbl[3]  = '{0,1,1,1,1, 47'h00100093,   1,1,1,1, 1,0};
    tbl[4]  = '{0,0,1,1,1, 47'h12345678,   1,0,1,1, 0,0};
    tbl[5]  = '{0,1,1,0,1, 47'h0,          1,1,1,0, 1,0};
    tbl[6]  = '{0,1,1,0,1, 47'h0,          1,1,1,0, 2,0};
    tbl[7]  = '{1,1,1,0,1, 47'h0,          0,0,1,0, 2,2};
    tbl[8]  = '{0,1,1,1,1, 47'h0AAAA,      0,0,1,0, 1,1};
    tbl[9]  = '{0,1,1,1,0, 47'h0BBBB,      1,1,1,0, 1,0};
    tbl[10] = '{0,0,1,1,0, 47'h0CCCC,      1,0,0,1, 1,0};
    tbl[11] = '{0,0,1,1,1, 47'h0CCCC,      1,0,1,1, 0,0};
    tbl[12] = '{0,1,0,0,1, 47'h0,          0,1,1,0, 0,0};
    tbl[13] = '{0,1,1,0,1, 47'h0,          1,1,1,0, 1,0};
    tbl[14] = '{0,1,1,0,1, 47'h0,          1,1,1,0, 2,0};
    tbl[15] = '{1,0,1,1,0, 47'h7FFF0000,   0,0,1,0, 1,1};
    tbl[16] = '{1,1,1,0,1, 47'h0,          1,1,1,0, 2,1};
    tbl[17] = '{0,0,1,1,1, 47'h11,         0,0,1,0, 1,0};
    tbl[18] = '{0,0,1,1,1, 47'h22,         1,0,1,1, 0,0};
    tbl[19] = '{1,0,1,0,0, 47'h0,          1,0,1,0, 0,0};

    reset = 1'b0;
    squash = 1'b0; req_in_val = 1'b0; req_out_rdy = 1'b0;
    resp_in_val = 1'b0; resp_out_rdy = 1'b0; resp_in_msg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.num_inflight",     64'(num_inflight),     64'(0));
    chk("reset.num_drop_pending", 64'(num_drop_pending), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].sq, tbl[i].rqv, tbl[i].ordy, tbl[i].rsv, tbl[i].rordy, tbl[i].msg);
      chk_comb($sformatf("row%0d", i), tbl[i].e_rqrdy, tbl[i].e_oval,
               tbl[i].e_rsrdy, tbl[i].e_rsoval);
      clock_and_chk_cnt($sformatf("row%0d", i), tbl[i].e_inf, tbl[i].e_drp);
    end

    // Reset mid-flight with inflight=2 and drop=1.
    apply(0,1,1,0,1, '0); clock_and_chk_cnt("rs1", 1, 0);
    apply(0,1,1,0,1, '0); clock_and_chk_cnt("rs2", 2, 0);
    apply(1,0,1,1,1, '0); clock_and_chk_cnt("rs3", 1, 1);
    apply(0,1,1,0,1, '0); clock_and_chk_cnt("rs4", 2, 1);
    apply(1,1,1,1,1, 47'h55);
    reset = 1'b0;
    clock_and_chk_cnt("rs5", 0, 0);
    @(negedge clk);
    reset = 1'b1;
    squash = 1'b0; resp_in_val = 1'b0;
    req_in_val = 1'b1; req_out_rdy = 1'b0;
    #1;
    chk("rs6.req_in_rdy", 64'(req_in_rdy), 64'(0));
    req_out_rdy = 1'b1;
    #1;
    chk("rs7.req_in_rdy", 64'(req_in_rdy), 64'(1));
    chk("rs7.req_out_val", 64'(req_out_val), 64'(1));
    req_in_val = 1'b0;
    clock_and_chk_cnt("rs8", 0, 0);

    q.delete();
    for (int c = 0; c < 3000; c++) begin
      sq    = ($urandom % 8) == 0;
      rqv   = 1'($urandom % 2);
      ordy  = ($urandom % 4) != 0;
      rsv   = (q.size() > 0) && (($urandom % 2) == 1);
      rordy = ($urandom % 4) != 0;
      m     = MSGW'({$urandom, $urandom});

      ndoom = 0;
      foreach (q[k]) if (q[k]) ndoom++;
      full     = q.size() >= MAXF;
      dropping = sq || (ndoom > 0);
      e_rqrdy  = ordy && !full;
      e_oval   = rqv && !full;
      e_rsrdy  = dropping ? 1'b1 : rordy;
      e_rsoval = !dropping && rsv;

      if (sq) foreach (q[k]) q[k] = 1'b1;
      if (rsv && e_rsrdy) void'(q.pop_front());
      if (rqv && e_rqrdy) q.push_back(1'b0);
      ndoom = 0;
      foreach (q[k]) if (q[k]) ndoom++;

      apply(sq, rqv, ordy, rsv, rordy, m);
      chk_comb($sformatf("rnd%0d", c), e_rqrdy, e_oval, e_rsrdy, e_rsoval);
      clock_and_chk_cnt($sformatf("rnd%0d", c), q.size(), ndoom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
